// File: rtl/mem_bus_pkg.sv
// mem_bus_pkg: shared FSM state codes, owner ids and decoder select codes for mem_bus_arbiter
package mem_bus_pkg;
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;
  typedef enum logic {M0 = 1'b0, M1 = 1'b1} owner_t;
  localparam logic [1:0] SEL_NONE = 2'b00;
endpackage

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: two request/response master ports plus the shared slave-side bus; slave = arbiter view, master = environment view
interface mem_bus_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  localparam int BE_W = DATA_W / 8;
  logic              m0_req, m0_we, m0_gnt, m0_rvalid, m0_err;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata, m0_rdata;
  logic [BE_W-1:0]   m0_be;
  logic              m1_req, m1_we, m1_gnt, m1_rvalid, m1_err;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata, m1_rdata;
  logic [BE_W-1:0]   m1_be;
  logic              bus_req, bus_we, bus_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic [DATA_W-1:0] bus_wdata, bus_rdata;
  logic [BE_W-1:0]   bus_be;
  logic [1:0]        bus_sel;
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata, m0_be,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    input  bus_sel, bus_ready, bus_rdata
  );
  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata, m0_be,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_be,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  bus_req, bus_we, bus_addr, bus_wdata, bus_be,
    output bus_sel, bus_ready, bus_rdata
  );
endinterface

// File: rtl/mem_bus_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin picker; ports clk, rst_n, req[1:0], advance -> one-hot gnt; ptr=0 prefers input 0
module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);
  logic ptr;
  always_comb gnt = ptr ? (req[1] ? 2'b10 : {1'b0, req[0]}) : (req[0] ? 2'b01 : {req[1], 1'b0});
  // after a grant the other input becomes preferred, giving strict alternation under contention
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) ptr <= 1'b0;
    else if (advance) ptr <= gnt[0];
endmodule

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin sharing of one memory bus between m0 (load/store) and m1 (fetch); ports clk, rst_n, io (slave modport: master req/resp + bus side)
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input logic                clk,
  input logic                rst_n,
  mem_bus_arbiter_if.slave   io
);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
  logic [1:0]          state, gnt;
  owner_t              owner;
  logic                we_q, err_q, take;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q, rdata_q;
  logic [DATA_W/8-1:0] be_q;
  logic [TMO_W-1:0]    cnt;
  rr_arb2 u_arb (.clk(clk), .rst_n(rst_n), .req({io.m1_req, io.m0_req}), .advance(take), .gnt(gnt));
  // gating with rst_n keeps gnt low while reset is held even though the FSM sits in IDLE
  assign take = rst_n && state == IDLE && |gnt;
  assign io.m0_gnt = take & gnt[0];
  assign io.m1_gnt = take & gnt[1];
  assign io.m0_rvalid = state == RESP && owner == M0;
  assign io.m1_rvalid = state == RESP && owner == M1;
  assign io.m0_rdata = io.m0_rvalid ? rdata_q : '0;
  assign io.m1_rdata = io.m1_rvalid ? rdata_q : '0;
  assign io.m0_err = io.m0_rvalid & err_q;
  assign io.m1_err = io.m1_rvalid & err_q;
  assign io.bus_req = state == BUSY && io.bus_sel != SEL_NONE;
  assign io.bus_we = we_q;
  assign io.bus_addr = addr_q;
  assign io.bus_wdata = wdata_q;
  assign io.bus_be = be_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      owner   <= M0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      cnt     <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (take) begin
      state   <= BUSY;
      owner   <= gnt[1] ? M1 : M0;
      we_q    <= gnt[1] ? io.m1_we : io.m0_we;
      addr_q  <= gnt[1] ? io.m1_addr : io.m0_addr;
      wdata_q <= gnt[1] ? io.m1_wdata : io.m0_wdata;
      be_q    <= gnt[1] ? io.m1_be : io.m0_be;
      cnt     <= '0;
    end else if (state == BUSY) begin
      if (io.bus_sel == SEL_NONE || (!io.bus_ready && cnt == TMO_LAST)) begin
        state   <= RESP;
        err_q   <= 1'b1;
        rdata_q <= '0;
      end else if (io.bus_ready) begin
        state   <= RESP;
        err_q   <= 1'b0;
        rdata_q <= we_q ? '0 : io.bus_rdata;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (state == RESP) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: directed self-checking bench for mem_bus_arbiter (TIMEOUT_CYCLES=4)
module tb_mem_bus_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  mem_bus_arbiter_if #(.ADDR_W(32), .DATA_W(32)) io ();
  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (.clk(clk), .rst_n(rst_n), .io(io));
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  initial begin
    io.m0_req = 0; io.m0_we = 0; io.m0_addr = 0; io.m0_wdata = 0; io.m0_be = 0;
    io.m1_req = 0; io.m1_we = 0; io.m1_addr = 0; io.m1_wdata = 0; io.m1_be = 0;
    io.bus_sel = 2'b01; io.bus_ready = 0; io.bus_rdata = 0;
    tick; tick;
    io.m0_req = 1; #1;
    chk("rst_m0_gnt", io.m0_gnt, 0);
    chk("rst_bus_req", io.bus_req, 0);
    chk("rst_bus_addr", io.bus_addr, 0);
    chk("rst_m0_rvalid", io.m0_rvalid, 0);
    io.m0_req = 0;
    tick;
    rst_n = 1;
    tick;
    // sustained contention: m0 first, then strict alternation
    io.m0_addr = 32'h100; io.m1_addr = 32'h200; io.m0_be = 4'hF; io.m1_be = 4'hF;
    io.m0_req = 1; io.m1_req = 1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk($sformatf("alt%0d_m0_gnt", k), io.m0_gnt, (k % 2 == 0));
      chk($sformatf("alt%0d_m1_gnt", k), io.m1_gnt, (k % 2 == 1));
      tick;
      chk($sformatf("alt%0d_busy_gnt", k), {io.m1_gnt, io.m0_gnt}, 0);
      chk($sformatf("alt%0d_addr", k), io.bus_addr, (k % 2 == 0) ? 32'h100 : 32'h200);
      io.bus_ready = 1; io.bus_rdata = 32'hA000 + k;
      tick;
      io.bus_ready = 0;
      chk($sformatf("alt%0d_m0_rvalid", k), io.m0_rvalid, (k % 2 == 0));
      chk($sformatf("alt%0d_m1_rvalid", k), io.m1_rvalid, (k % 2 == 1));
      chk($sformatf("alt%0d_rdata", k), (k % 2 == 0) ? io.m0_rdata : io.m1_rdata, 32'hA000 + k);
      tick;
    end
    io.m0_req = 0; io.m1_req = 0;
    tick;
    // m0 read from SRAM, ready two cycles after grant
    io.m0_req = 1; io.m0_we = 0; io.m0_addr = 32'h8000_2004; io.bus_sel = 2'b01; #1;
    chk("rd_m0_gnt", io.m0_gnt, 1);
    tick;
    io.m0_req = 0;
    chk("rd_bus_addr", io.bus_addr, 32'h8000_2004);
    chk("rd_bus_req", io.bus_req, 1);
    chk("rd_bus_we", io.bus_we, 0);
    tick;
    io.bus_ready = 1; io.bus_rdata = 32'hDEAD_BEEF; #1;
    chk("rd_early_rvalid", io.m0_rvalid, 0);
    tick;
    io.bus_ready = 0; io.bus_rdata = 0;
    chk("rd_rvalid", io.m0_rvalid, 1);
    chk("rd_rdata", io.m0_rdata, 32'hDEAD_BEEF);
    chk("rd_err", io.m0_err, 0);
    chk("rd_m1_rvalid", io.m1_rvalid, 0);
    chk("rd_resp_bus_req", io.bus_req, 0);
    tick;
    chk("rd_rvalid_pulse", io.m0_rvalid, 0);
    // m1 write: rdata must read back 0 even if the slave drives data
    io.m1_req = 1; io.m1_we = 1; io.m1_addr = 32'h1000_0000; io.m1_wdata = 32'h41; io.m1_be = 4'b0001;
    io.bus_sel = 2'b10; #1;
    chk("wr_m1_gnt", io.m1_gnt, 1);
    tick;
    io.m1_req = 0;
    chk("wr_bus_we", io.bus_we, 1);
    chk("wr_bus_addr", io.bus_addr, 32'h1000_0000);
    chk("wr_bus_wdata", io.bus_wdata, 32'h41);
    chk("wr_bus_be", io.bus_be, 4'b0001);
    io.bus_ready = 1; io.bus_rdata = 32'hFFFF_FFFF;
    tick;
    io.bus_ready = 0;
    chk("wr_rvalid", io.m1_rvalid, 1);
    chk("wr_rdata", io.m1_rdata, 0);
    chk("wr_err", io.m1_err, 0);
    chk("wr_m0_rvalid", io.m0_rvalid, 0);
    tick;
    // unmapped address: error wins over a stray ready
    io.m0_req = 1; io.m0_we = 0; io.m0_addr = 32'h0000_0100; io.bus_sel = 2'b00; #1;
    chk("um_m0_gnt", io.m0_gnt, 1);
    tick;
    io.m0_req = 0;
    io.bus_ready = 1; io.bus_rdata = 32'h1234; #1;
    chk("um_bus_req", io.bus_req, 0);
    tick;
    io.bus_ready = 0;
    chk("um_rvalid", io.m0_rvalid, 1);
    chk("um_err", io.m0_err, 1);
    chk("um_rdata", io.m0_rdata, 0);
    tick;
    // timeout after 4 busy cycles
    io.m0_req = 1; io.m0_addr = 32'h8000_0000; io.bus_sel = 2'b01; #1;
    chk("to_m0_gnt", io.m0_gnt, 1);
    tick;
    io.m0_req = 0;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("to_bus_req%0d", k), io.bus_req, 1);
      chk($sformatf("to_rvalid%0d", k), io.m0_rvalid, 0);
      tick;
    end
    chk("to_rvalid", io.m0_rvalid, 1);
    chk("to_err", io.m0_err, 1);
    chk("to_rdata", io.m0_rdata, 0);
    chk("to_resp_bus_req", io.bus_req, 0);
    tick;
    // ready while idle is ignored
    io.bus_ready = 1;
    tick;
    io.bus_ready = 0;
    chk("idle_ready_rvalid", io.m0_rvalid | io.m1_rvalid, 0);
    // reset in BUSY after granting m0 (pointer moved to m1)
    io.m0_req = 1; io.m0_addr = 32'h8000_0040; #1;
    chk("rb_m0_gnt", io.m0_gnt, 1);
    tick;
    io.m0_req = 0;
    chk("rb_bus_req", io.bus_req, 1);
    rst_n = 0; #1;
    chk("rb_bus_req_rst", io.bus_req, 0);
    chk("rb_bus_addr_rst", io.bus_addr, 0);
    chk("rb_rvalid_rst", io.m0_rvalid, 0);
    tick;
    rst_n = 1;
    io.bus_ready = 1;
    tick;
    io.bus_ready = 0;
    chk("rb_no_rvalid0", io.m0_rvalid | io.m1_rvalid, 0);
    tick;
    chk("rb_no_rvalid1", io.m0_rvalid | io.m1_rvalid, 0);
    io.m0_req = 1; io.m1_req = 1; #1;
    chk("rb_ptr_m0_gnt", io.m0_gnt, 1);
    chk("rb_ptr_m1_gnt", io.m1_gnt, 0);
    tick;
    io.m0_req = 0; io.m1_req = 0;
    io.bus_ready = 1; io.bus_rdata = 32'h5;
    tick;
    io.bus_ready = 0;
    chk("rb_after_rvalid", io.m0_rvalid, 1);
    tick;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
